// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory loader.
// Loader FSM states and sticky error codes live here.
package imem_pkg;

  localparam int unsigned ADDR_W         = 9;
  localparam int unsigned DATA_W         = 33;
  localparam int unsigned BYTES_PER_WORD = 5;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StWrite,
    StCsum,
    StDone,
    StError
  } loader_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte shift-in for one instruction word; word_ready marks
// the handshake of the final byte so the completed word is visible next cycle.
module imem_word_assembler #(
  parameter int unsigned DATA_W         = imem_pkg::DATA_W,
  parameter int unsigned BYTES_PER_WORD = imem_pkg::BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_ready
);
  import imem_pkg::*;

  localparam int unsigned SrW  = 8 * BYTES_PER_WORD;
  localparam int unsigned CntW = $clog2(BYTES_PER_WORD);
  localparam logic [CntW-1:0] LastIdx = CntW'(BYTES_PER_WORD - 1);

  logic [SrW-1:0]  sr_q;
  logic [CntW-1:0] cnt_q;

  assign word_ready = shift && (cnt_q == LastIdx);
  // Upper pad bits of the final byte fall outside the word and are dropped.
  assign word       = sr_q[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (shift) begin
      sr_q  <= {byte_in, sr_q[SrW-1:8]};
      cnt_q <= word_ready ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory: length, data words, XOR
// checksum. Holds the CPU while loading and reports sticky done/error status.
module imem_loader #(
  parameter int unsigned ADDR_W         = imem_pkg::ADDR_W,
  parameter int unsigned DATA_W         = imem_pkg::DATA_W,
  parameter int unsigned BYTES_PER_WORD = imem_pkg::BYTES_PER_WORD,
  parameter int unsigned TIMEOUT_CYC    = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);
  import imem_pkg::*;

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CntW = ADDR_W + 1;

  loader_state_e   state_q, state_d;
  err_code_e       err_q, err_d;
  logic [15:0]     len_q, len_d, len_full;
  logic [7:0]      csum_q, csum_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [CntW-1:0] words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic            hold_q, hold_d, busy_q, busy_d, done_q, done_d;
  logic            accept, start_frame, word_ready, len_bad;

  assign rx_ready = state_q inside {StLenLo, StLenHi, StData, StCsum};
  assign accept   = rx_valid && rx_ready;
  assign len_full = {rx_data, len_q[7:0]};
  assign len_bad  = (len_full == 16'd0) || (32'(len_full) > (32'd1 << ADDR_W));

  imem_word_assembler #(
    .DATA_W        (DATA_W),
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_frame),
    .shift     (accept && (state_q == StData)),
    .byte_in   (rx_data),
    .word      (mem_data),
    .word_ready(word_ready)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    len_d       = len_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    words_d     = words_q;
    addr_d      = addr_q;
    start_frame = 1'b0;

    // Idle-cycle watchdog for every state that waits on the host link.
    if (rx_ready) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
        state_d = StError;
        err_d   = ERR_TIMEOUT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          start_frame = 1'b1;
          state_d     = StLenLo;
          err_d       = ERR_NONE;
          words_d     = '0;
          addr_d      = '0;
          csum_d      = '0;
          tmo_d       = '0;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d   = {8'h00, rx_data};
          csum_d  = csum_q ^ rx_data;
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d  = len_full;
          csum_d = csum_q ^ rx_data;
          if (len_bad) begin
            state_d = StError;
            err_d   = ERR_LEN;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          if (word_ready) begin
            state_d = StWrite;
            addr_d  = words_q[ADDR_W-1:0];
          end
        end
      end
      StWrite: begin
        words_d = words_q + 1'b1;
        state_d = (32'(words_d) == 32'(len_q)) ? StCsum : StData;
      end
      StCsum: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d = StDone;
          end else begin
            state_d = StError;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    hold_d = state_d inside {StLenLo, StLenHi, StData, StWrite, StCsum, StError};
    busy_d = state_d inside {StLenLo, StLenHi, StData, StWrite, StCsum};
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      err_q   <= ERR_NONE;
      len_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_wren     = (state_q == StWrite);
  assign mem_addr     = addr_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_code     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from word lists and
// the observed write stream is compared against the expected memory image.
module tb_imem_loader;
  localparam int unsigned AW  = 9;
  localparam int unsigned DW  = 33;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, mem_wren, cpu_hold, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [1:0] err_code;
  logic [AW:0] words_loaded;

  int n_chk = 0, n_fail = 0;
  logic [7:0] frame[$];
  logic [DW-1:0] words[$];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  logic wren_prev = 1'b0;
  int wren_double = 0;

  imem_loader #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .BYTES_PER_WORD(5),
    .TIMEOUT_CYC   (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .mem_wren    (mem_wren),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .err_code    (err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor: records every write cycle and flags multi-cycle strobes.
  always @(negedge clk) begin
    if (rst && mem_wren) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
      if (wren_prev) wren_double <= wren_double + 1;
    end
    wren_prev <= mem_wren;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // Reference framing: length LE, each word as 5 LE bytes, XOR checksum.
  task automatic build_frame();
    logic [7:0] x;
    logic [15:0] n;
    logic [39:0] w;
    n = 16'(words.size());
    frame.delete();
    frame.push_back(n[7:0]);
    frame.push_back(n[15:8]);
    foreach (words[k]) begin
      w = {7'd0, words[k]};
      for (int b = 0; b < 5; b++) frame.push_back(w[8*b +: 8]);
    end
    x = 8'h00;
    foreach (frame[i]) x = x ^ frame[i];
    frame.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got;
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      got = rx_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!got && t < 100);
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL byte_accept: byte %h not taken, rx_ready=%b required 1", b, rx_ready);
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int max_gap);
    for (int i = lo; i < hi; i++) begin
      send_byte(frame[i]);
      if (max_gap > 0 && $urandom_range(0, 1) == 1) begin
        rx_valid = 1'b0;
        cyc($urandom_range(1, max_gap));
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(2);
    n_chk++;
    if ({rx_ready, mem_wren, mem_addr, mem_data, cpu_hold, busy, done, err_code, words_loaded}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b wren=%b addr=%h data=%h hold=%b busy=%b done=%b err=%0d wl=%0d required all 0",
               rx_ready, mem_wren, mem_addr, mem_data, cpu_hold, busy, done, err_code, words_loaded);
    end
    rst = 1'b1;
    cyc(2);
  endtask

  task automatic test_nominal(input logic [7:0] last, input bit good);
    int d0;
    d0 = wren_double;
    wr_addr.delete();
    wr_data.delete();
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h01, 8'h00, 8'hCD, 8'hAB, 8'h01, 8'h77};
    frame[12] = last;
    words = '{33'h0_00000013, 33'h1_ABCD0001};
    pulse_start();
    n_chk++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_on_start: hold=%b busy=%b required 1 1", cpu_hold, busy);
    end
    send_range(0, 13, 0);
    n_chk++;
    if (cpu_hold !== !good || done !== good || err_code !== (good ? 2'd0 : 2'd2)) begin
      n_fail++;
      $display("FAIL frame_status: hold=%b done=%b err=%0d required %b %b %0d",
               cpu_hold, done, err_code, !good, good, good ? 0 : 2);
    end
    cyc(3);
    n_chk++;
    if (wr_addr.size() != 2 || wren_double != d0) begin
      n_fail++;
      $display("FAIL nominal_writes: count=%0d long_strobes=%0d required 2 0",
               wr_addr.size(), wren_double - d0);
    end
    for (int k = 0; k < wr_addr.size() && k < 2; k++) begin
      n_chk++;
      if (wr_addr[k] !== AW'(k) || wr_data[k] !== words[k]) begin
        n_fail++;
        $display("FAIL nominal_word%0d: addr=%h data=%h required %h %h",
                 k, wr_addr[k], wr_data[k], k, words[k]);
      end
    end
    n_chk++;
    if (words_loaded !== 10'd2 || busy !== 1'b0 || cpu_hold !== !good) begin
      n_fail++;
      $display("FAIL nominal_final: wl=%0d busy=%b hold=%b required 2 0 %b",
               words_loaded, busy, cpu_hold, !good);
    end
  endtask

  task automatic test_bad_len();
    wr_addr.delete();
    frame = '{8'h00, 8'h00};
    pulse_start();
    n_chk++;
    if (err_code !== 2'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clears: err=%0d done=%b required 0 0", err_code, done);
    end
    send_range(0, 2, 0);
    n_chk++;
    if (err_code !== 2'd1 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL len_zero: err=%0d busy=%b hold=%b required 1 0 1", err_code, busy, cpu_hold);
    end
    frame = '{8'h01, 8'h02};
    pulse_start();
    send_range(0, 2, 0);
    cyc(3);
    n_chk++;
    if (err_code !== 2'd1 || wr_addr.size() != 0 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL len_513: err=%0d writes=%0d rdy=%b required 1 0 0",
               err_code, wr_addr.size(), rx_ready);
    end
  endtask

  task automatic test_backpressure();
    for (int it = 0; it < 3; it++) begin
      wr_addr.delete();
      wr_data.delete();
      words.delete();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++)
        words.push_back(DW'({$urandom(), $urandom()}));
      build_frame();
      pulse_start();
      send_range(0, 2, 3);
      pulse_start();
      n_chk++;
      if (busy !== 1'b1 || err_code !== 2'd0) begin
        n_fail++;
        $display("FAIL start_ignored: busy=%b err=%0d required 1 0", busy, err_code);
      end
      send_range(2, frame.size(), 3);
      cyc(2);
      n_chk++;
      if (wr_addr.size() != words.size() || done !== 1'b1 || err_code !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_status%0d: writes=%0d done=%b err=%0d required %0d 1 0",
                 it, wr_addr.size(), done, err_code, words.size());
      end
      for (int k = 0; k < wr_addr.size() && k < words.size(); k++) begin
        n_chk++;
        if (wr_addr[k] !== AW'(k) || wr_data[k] !== words[k]) begin
          n_fail++;
          $display("FAIL bp_word%0d_%0d: addr=%h data=%h required %h %h",
                   it, k, wr_addr[k], wr_data[k], k, words[k]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    wr_addr.delete();
    words = '{33'h13, 33'h0};
    build_frame();
    pulse_start();
    send_range(0, 3, 0);
    cyc(10);
    n_chk++;
    if (busy !== 1'b1 || err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_early: busy=%b err=%0d required 1 0", busy, err_code);
    end
    cyc(10);
    n_chk++;
    if (err_code !== 2'd3 || busy !== 1'b0 || cpu_hold !== 1'b1 || wr_addr.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: err=%0d busy=%b hold=%b writes=%0d required 3 0 1 0",
               err_code, busy, cpu_hold, wr_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    wr_addr.delete();
    words = '{33'h13, 33'h0};
    build_frame();
    pulse_start();
    send_range(0, 5, 0);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({rx_ready, mem_wren, mem_addr, mem_data, cpu_hold, busy, done, err_code, words_loaded}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%b wren=%b addr=%h data=%h hold=%b busy=%b wl=%0d required all 0",
               rx_ready, mem_wren, mem_addr, mem_data, cpu_hold, busy, words_loaded);
    end
    cyc(3);
    rst = 1'b1;
    cyc(10);
    n_chk++;
    if (wr_addr.size() != 0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: writes=%0d busy=%b hold=%b required 0 0 0",
               wr_addr.size(), busy, cpu_hold);
    end
  endtask

  task automatic test_max_frame();
    int errs;
    wr_addr.delete();
    wr_data.delete();
    words.delete();
    for (int k = 0; k < 512; k++) words.push_back(DW'(k));
    build_frame();
    pulse_start();
    send_range(0, frame.size(), 0);
    cyc(2);
    n_chk++;
    if (wr_addr.size() != 512 || words_loaded !== 10'd512 || done !== 1'b1 ||
        err_code !== 2'd0 || mem_addr !== 9'd511) begin
      n_fail++;
      $display("FAIL max_status: writes=%0d wl=%0d done=%b err=%0d addr=%0d required 512 512 1 0 511",
               wr_addr.size(), words_loaded, done, err_code, mem_addr);
    end
    errs = 0;
    for (int k = 0; k < wr_addr.size() && k < 512; k++) begin
      n_chk++;
      if (wr_addr[k] !== AW'(k) || wr_data[k] !== words[k]) begin
        n_fail++;
        errs++;
        if (errs < 5)
          $display("FAIL max_word%0d: addr=%0d data=%h required %0d %h",
                   k, wr_addr[k], wr_data[k], k, words[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal(8'h77, 1'b1);
    test_nominal(8'h76, 1'b0);
    test_bad_len();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_max_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded 1ms, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the fetch stage's instruction-memory read port.
- Receives a framed byte stream from the host link (UART receiver, valid/ready) and assembles 33-bit instruction words.
- Writes those words sequentially into Instruction_Memory starting at address 0.
- Holds the processor (cpu_hold) while loading; reports done/error status.

Parameters:
- ADDR_W, 9, instruction memory address width (matches PC width).
- DATA_W, 33, instruction word width.
- BYTES_PER_WORD, 5, bytes per word, ceil(DATA_W/8).
- TIMEOUT_CYC, 1000000, max idle cycles between accepted bytes while a frame is open.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; begins a new load frame.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts byte this cycle.
- mem_wren  out  1  instruction memory write enable.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  DATA_W  write data.
- cpu_hold  out  1  high = processor held in reset/stall.
- busy  out  1  frame in progress.
- done  out  1  last frame completed OK (sticky until next start).
- err_code  out  2  0 none, 1 bad length, 2 checksum, 3 timeout (sticky until next start).
- words_loaded  out  ADDR_W+1  words written in current/last frame.

Behaviour:
- Reset values: rx_ready=0, mem_wren=0, mem_addr=0, mem_data=0, cpu_hold=0, busy=0, done=0, err_code=0, words_loaded=0, state IDLE.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian); N*5 data bytes, each word little-endian, bits [39:33] of byte 4 ignored; 1 checksum byte = XOR of every byte from LEN_LO through the last data byte.
- Handshake: a byte is consumed when rx_valid && rx_ready. rx_ready=1 only in LEN_LO, LEN_HI, DATA, CSUM. rx_data is not sampled otherwise.
- States:
  - IDLE: start -> LEN_LO; clear done, err_code, words_loaded, checksum, byte index.
  - LEN_LO -> LEN_HI on accept.
  - LEN_HI: on accept, if N==0 or N>2^ADDR_W -> ERROR code 1; else -> DATA.
  - DATA: the shift register collects bytes; on the 5th byte accept -> WRITE.
  - WRITE: exactly one cycle, rx_ready=0. mem_wren=1, mem_addr=word index, mem_data=assembled word. words_loaded increments; word index +1. If words_loaded reaches N -> CSUM, else -> DATA.
  - CSUM: on accept, compare against running XOR; match -> DONE, mismatch -> ERROR code 2.
  - DONE: done=1. start -> LEN_LO.
  - ERROR: err_code held. start -> LEN_LO.
- Latency: mem_wren asserts the cycle after the 5th byte's handshake; one word takes at least 6 cycles.
- cpu_hold=1 in LEN_LO, LEN_HI, DATA, WRITE, CSUM, ERROR; 0 in IDLE and DONE. It is registered and glitch-free.
- busy=1 in LEN_LO through CSUM.
- start while busy is ignored (no restart, no clear).
- Timeout: counter clears on each accepted byte and on entry to LEN_LO. It counts while in LEN_LO/LEN_HI/DATA/CSUM. Reaching TIMEOUT_CYC -> ERROR code 3. Words already written stay in memory.
- N==512 is legal: last address 511. mem_addr never wraps within a frame.
- Reset mid-frame: immediate return to IDLE, all outputs to reset values, any pending partial word discarded, no further writes.

Decomposition:
- Shared package imem_pkg: ADDR_W, DATA_W, BYTES_PER_WORD constants; loader state enum; err_code enum (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT).
- One natural sub-module: imem_word_assembler (byte shift-in, byte count, word_ready pulse, clear). FSM, checksum and timeout stay in imem_loader.

Test Plan:
- Nominal load: start; bytes 02 00 13 00 00 00 00 01 00 CD AB 01 77 with rx_valid always high -> writes addr0=0x0_00000013, addr1=0x1_ABCD0001. mem_wren exactly 2 single-cycle pulses; done=1, err_code=0, words_loaded=2, cpu_hold falls after CSUM accept.
- Checksum error: same frame with last byte 0x76 -> both writes occur; err_code=2, done=0, cpu_hold stays 1 until next start.
- Bad length: bytes 00 00, then separately 01 02 (N=513) -> ERROR code 1 right after LEN_HI accept; no mem_wren.
- Backpressure/gaps: rx_valid toggled randomly, and rx_valid held during WRITE cycle -> byte not consumed in WRITE; data identical to nominal.
- Timeout: TIMEOUT_CYC=16; send 02 00 13 then idle 16 cycles -> err_code=3, no mem_wren, busy=0.
- Reset mid-frame and max frame: rst low after 3 data bytes -> all outputs zero, no write. Then a 512-word frame (word k = k) -> last write addr 511 data 511, words_loaded=512, done=1.
